// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Multi-cycle EX-stage ALU. It takes a 4-bit alu_control code and two XLEN-bit
//   operands with a valid/ready handshake. After LATENCY cycles it presents a
//   registered result, zero and illegal, also with a valid/ready handshake.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-high
//   in_valid     in   operation request valid
//   in_ready     out  unit can accept a request this cycle
//   alu_control  in   0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1111 NOP
//   operand_a    in   first operand (rs1)
//   operand_b    in   second operand (rs2 or immediate)
//   out_valid    out  result/zero/illegal valid
//   out_ready    in   consumer accepts result this cycle
//   result       out  operation result
//   zero         out  result == 0
//   illegal      out  alu_control was not a legal code
//
// State table
//   IDLE | no operation held, ready for a request
//   BUSY | operation captured, counting down the remaining latency
//   DONE | result presented, waiting for out_ready

module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count, count_next;
    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic            accept;
    logic            load_result;
    logic [3:0]      src_op;
    logic [XLEN-1:0] src_a, src_b;
    logic [XLEN-1:0] res_calc;
    logic            ill_calc;

    // Reset gating keeps the unit from claiming readiness while rst is asserted.
    assign in_ready  = !rst && ((state == IDLE) || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                        count_next = CW'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                count_next = count - 1'b1;
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                        count_next = CW'(LATENCY - 1);
                    end
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= alu_control;
            a_q  <= operand_a;
            b_q  <= operand_b;
        end
    end

    // With a single-cycle latency the result register loads on the accept edge itself.
    // In that case it has to see the incoming operands, not the captured copies.
    assign load_result = (LATENCY == 1) ? accept : (state == BUSY && count == CW'(1));
    assign src_op      = (LATENCY == 1) ? alu_control : op_q;
    assign src_a       = (LATENCY == 1) ? operand_a   : a_q;
    assign src_b       = (LATENCY == 1) ? operand_b   : b_q;

    always_comb begin
        res_calc = '0;
        ill_calc = 1'b0;
        case (src_op)
            4'b0000: res_calc = src_a & src_b;
            4'b0001: res_calc = src_a | src_b;
            4'b0010: res_calc = src_a + src_b;
            4'b0110: res_calc = src_a + ~src_b + XLEN'(1);
            4'b0111: res_calc = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b1111: res_calc = '0;
            default: ill_calc = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (load_result) begin
            result  <= res_calc;
            zero    <= (res_calc == '0);
            illegal <= ill_calc;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Scoreboard bench for alu_exec_unit. A monitor watches handshakes on the negative
//   clock edge. On each accepted request it pushes the expected response and the
//   accept cycle into a queue. It checks out_valid/in_ready timing and the presented
//   result against the head of the queue. Directed cases are followed by randomized
//   traffic with random output backpressure.

module tb_alu_exec_unit;

    localparam int XLEN = 32;
    localparam int LAT  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      alu_control = 4'd0;
    logic [XLEN-1:0] operand_a = '0;
    logic [XLEN-1:0] operand_b = '0;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit   rand_or  = 1'b0;
    logic or_force = 1'b1;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            zf;
        logic            ill;
        int              acc_cyc;
    } exp_t;

    exp_t sb[$];
    bit   ev_m, er_m;

    alu_exec_unit #(.XLEN(XLEN), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_or ? ($urandom_range(0, 3) != 0) : or_force;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", nm, cyc);
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input int c);
        exp_t e;
        e.res     = '0;
        e.ill     = 1'b0;
        e.acc_cyc = c;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1111: e.res = '0;
            default: e.ill = 1'b1;
        endcase
        e.zf = (e.res == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_result", result, 0);
            chk("rst_zero", zero, 0);
            chk("rst_illegal", illegal, 0);
        end else begin
            ev_m = (sb.size() > 0) && (cyc >= sb[0].acc_cyc + LAT);
            er_m = (sb.size() == 0) || (ev_m && out_ready);
            chk("out_valid", out_valid, ev_m);
            chk("in_ready", in_ready, er_m);
            if (ev_m) begin
                chk("result", result, sb[0].res);
                chk("zero", zero, sb[0].zf);
                chk("illegal", illegal, sb[0].ill);
                if (out_ready) void'(sb.pop_front());
            end
            if (in_valid && er_m)
                sb.push_back(model(alu_control, operand_a, operand_b, cyc));
        end
    end

    // Call at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic send(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int k;
        in_valid    = 1'b1;
        alu_control = op;
        operand_a   = a;
        operand_b   = b;
        k = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 50) begin
                timeout_fail("send_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        operand_a   = $urandom;
        operand_b   = $urandom;
    endtask

    task automatic wait_out(input string nm, input logic [XLEN-1:0] er, input logic ez, input logic ei);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                chk({nm, "_result"}, result, er);
                chk({nm, "_zero"}, zero, ez);
                chk({nm, "_illegal"}, illegal, ei);
                break;
            end
            k++;
            if (k > 50) begin
                timeout_fail(nm);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rand_op();
        logic [3:0] legal [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1111};
        if ($urandom_range(0, 4) == 0) return 4'($urandom);
        return legal[$urandom_range(0, 5)];
    endfunction

    initial begin
        int k;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // reset while an ADD is in flight: nothing may come out afterwards
        send(4'b0010, 32'd10, 32'd20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_result", result, 0);
        repeat (4) @(posedge clk);
        #1;

        send(4'b0010, 32'hFFFF_FFFF, 32'h1);
        wait_out("add_wrap", 32'h0, 1'b1, 1'b0);
        send(4'b0110, 32'd5, 32'd5);
        wait_out("sub_eq", 32'h0, 1'b1, 1'b0);
        send(4'b0110, 32'd3, 32'd5);
        wait_out("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0);
        send(4'b0111, 32'hFFFF_FFFF, 32'd1);
        wait_out("slt_true", 32'd1, 1'b0, 1'b0);
        send(4'b0111, 32'd1, 32'hFFFF_FFFF);
        wait_out("slt_false", 32'd0, 1'b1, 1'b0);
        send(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_out("illegal_op", 32'd0, 1'b1, 1'b1);
        send(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_out("nop", 32'd0, 1'b1, 1'b0);

        // backpressure in DONE with changing inputs, then back-to-back accept
        or_force = 1'b0;
        send(4'b0001, 32'h0000_1234, 32'h0000_4321);
        repeat (LAT + 5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            in_valid    = 1'($urandom);
            alu_control = rand_op();
            operand_a   = $urandom;
            operand_b   = $urandom;
        end
        @(negedge clk);
        chk("bp_held_result", result, 32'h0000_5335);
        @(posedge clk);
        #1;
        or_force = 1'b1;
        send(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
        wait_out("b2b_and", 32'h0000_F000, 1'b0, 1'b0);

        // randomized traffic with random backpressure
        rand_or = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send(rand_op(), rand_val(), rand_val());
        end
        rand_or  = 1'b0;
        or_force = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) timeout_fail("drain");
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
